// File: rtl/lsu_ext.sv
// Load/store unit with byte/half/word lane placement, load extension and misalignment detection.
// Optional ack timeout is built only when LSU_TIMEOUT_EN is defined.
module lsu_ext #(
    parameter int TO_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        MemWr,
    input  logic [1:0]  Size,
    input  logic        ExtOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        busy,
    output logic        done,
    output logic [31:0] RData,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        ext_q, ext_d;
    logic [1:0]  lane_q, lane_d;
    logic        misalign_q, misalign_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        start_mis;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic        to_hit;

    assign accept = (state_q == S_IDLE) & start;

    assign start_mis = (Size == 2'b11)
                     | ((Size == SZ_HALF) & Addr[0])
                     | ((Size == SZ_WORD) & (Addr[1:0] != 2'b00));

    // Stores replicate the narrow datum on every lane; byte enables pick the real one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        case (Size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << Addr[1:0];
                st_wdata = {4{WData[7:0]}};
            end
            SZ_HALF: begin
                st_be    = 4'b0011 << {Addr[1], 1'b0};
                st_wdata = {2{WData[15:0]}};
            end
            SZ_WORD: begin
                st_be    = 4'b1111;
                st_wdata = WData;
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = 8'h0;
        case (lane_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{ext_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_val = {{16{ext_q & lane_half[15]}}, lane_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        ext_d      = ext_q;
        lane_d     = lane_q;
        misalign_d = misalign_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d       = MemWr;
                    be_d       = MemWr ? st_be : 4'b1111;
                    addr_d     = Addr[31:2];
                    wdata_d    = st_wdata;
                    size_d     = Size;
                    ext_d      = ExtOp;
                    lane_d     = Addr[1:0];
                    misalign_d = start_mis;
                    state_d    = start_mis ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = load_val;
                    end
                end else if (to_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            ext_q      <= 1'b0;
            lane_q     <= 2'b00;
            misalign_q <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q    <= state_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            ext_q      <= ext_d;
            lane_q     <= lane_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    assign to_hit = (cnt_q == CNT_W'(TO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_ACCESS) ? cnt_q + CNT_W'(1) : '0;
            if (accept) begin
                timeout_q <= 1'b0;
            end else if ((state_q == S_ACCESS) && !mem_ack && to_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // The bus is driven only while an access is outstanding, so reset drops it immediately.
    assign busy      = (state_q == S_ACCESS);
    assign done      = (state_q == S_DONE);
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_be    = busy ? be_q : 4'b0000;
    assign mem_addr  = busy ? {addr_q, 2'b00} : 32'h0;
    assign mem_wdata = busy ? wdata_q : 32'h0;
    assign misalign  = misalign_q;
    assign RData     = rdata_q;

endmodule

// File: tb/tb_lsu_ext.sv
// Self-checking bench for lsu_ext: directed scenarios plus random accesses against a lane/extension model.
module tb_lsu_ext;

    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        MemWr;
    logic [1:0]  Size;
    logic        ExtOp;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        busy;
    logic        done;
    logic [31:0] RData;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_ext #(.TO_CYC(TO_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .MemWr    (MemWr),
        .Size     (Size),
        .ExtOp    (ExtOp),
        .Addr     (Addr),
        .WData    (WData),
        .busy     (busy),
        .done     (done),
        .RData    (RData),
        .misalign (misalign),
        .timeout  (timeout),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: alignment, byte enables, store replication and load extension.
    function automatic logic ref_misalign(input logic [1:0] size, input logic [31:0] addr);
        int unsigned bytes;
        case (size)
            2'd0:    bytes = 1;
            2'd1:    bytes = 2;
            2'd2:    bytes = 4;
            default: return 1'b1;
        endcase
        return (addr % bytes) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        int unsigned n = addr % 4;
        if (!wr) return 4'hF;
        case (size)
            2'd0:    return 4'(1 << n);
            2'd1:    return 4'(3 << (2 * (n / 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    return (wdata & 32'hFF) * 32'h01010101;
            2'd1:    return (wdata & 32'hFFFF) * 32'h00010001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic ext,
                                             input logic [31:0] addr, input logic [31:0] word);
        int unsigned n = addr % 4;
        logic [31:0] v;
        case (size)
            2'd0: begin
                v = (word >> (8 * n)) & 32'hFF;
                if (ext && v >= 32'd128) v = v - 32'd256;
            end
            2'd1: begin
                v = (word >> (16 * (n / 2))) & 32'hFFFF;
                if (ext && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    // One complete access: start in cycle 0, ack in cycle k, done in cycle k+1, idle in k+2.
    task automatic run_access(input logic wr, input logic [1:0] size, input logic ext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int k, input logic hold_start);
        logic mis = ref_misalign(size, addr);
        start = 1'b1; MemWr = wr; Size = size; ExtOp = ext; Addr = addr; WData = wdata;
        mem_ack = 1'b0;
        tick();
        if (hold_start) begin
            Addr  = addr ^ 32'h0000_0100;
            WData = ~wdata;
        end else begin
            start = 1'b0;
        end
        if (!mis) begin
            for (int c = 1; c <= k; c++) begin
                check("req", mem_req, 1'b1);
                check("busy", busy, 1'b1);
                check("done_early", done, 1'b0);
                check("we", mem_we, wr);
                check("be", mem_be, ref_be(wr, size, addr));
                check("maddr", mem_addr, addr & 32'hFFFF_FFFC);
                if (wr) check("wdata", mem_wdata, ref_wdata(size, wdata));
                if (c == k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                tick();
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            if (!wr) exp_rdata = ref_load(size, ext, addr, rdata);
        end
        check("done", done, 1'b1);
        check("misalign", misalign, mis);
        check("timeout", timeout, 1'b0);
        check("req_done", mem_req, 1'b0);
        check("busy_done", busy, 1'b0);
        check("rdata", RData, exp_rdata);
        tick();
        start = 1'b0;
        check("done_pulse", done, 1'b0);
        check("req_idle", mem_req, 1'b0);
        check("busy_idle", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; MemWr = 1'b0; Size = 2'b00; ExtOp = 1'b0;
        Addr = 32'h0; WData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset state, with start held high to show it is ignored under reset.
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_rdata", RData, 32'h0);
        check("rst_mis", misalign, 1'b0);
        check("rst_to", timeout, 1'b0);
        check("rst_be", mem_be, 4'h0);
        check("rst_addr", mem_addr, 32'h0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        // Half load, sign and zero extension; byte load.
        run_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hC08F1234, 2, 1'b0);
        check("hsign", RData, 32'hFFFFC08F);
        run_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hC08F1234, 2, 1'b0);
        check("hzero", RData, 32'h0000C08F);
        run_access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'hC08F1234, 1, 1'b0);
        check("bsign", RData, 32'h00000012);

        // Byte store on the top lane, start held through the access.
        run_access(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 32'h0, 3, 1'b1);

        // Misaligned accesses leave RData untouched.
        run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1, 1'b0);
        check("mis_keep", RData, 32'h00000012);
        run_access(1'b0, 2'b01, 1'b1, 32'h305, 32'h0, 32'h0, 1, 1'b0);
        run_access(1'b1, 2'b11, 1'b0, 32'h300, 32'h0, 32'h0, 1, 1'b0);

        // Stray ack while idle does nothing.
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        check("stray_done", done, 1'b0);
        check("stray_rdata", RData, exp_rdata);

        // Random accesses.
        for (int i = 0; i < 40; i++) begin
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        // Reset during ACCESS, then a late ack.
        start = 1'b1; MemWr = 1'b1; Size = 2'b10; Addr = 32'h400; WData = 32'h12345678;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check("ar_req", mem_req, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_we", mem_we, 1'b0);
        check("ar_be", mem_be, 4'h0);
        check("ar_addr", mem_addr, 32'h0);
        check("ar_wdata", mem_wdata, 32'h0);
        check("ar_rdata", RData, 32'h0);
        check("ar_done", done, 1'b0);
        check("ar_mis", misalign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        check("late_ack_done", done, 1'b0);
        check("late_ack_req", mem_req, 1'b0);
        check("late_ack_rdata", RData, 32'h0);

        // Ack never arrives.
        start = 1'b1; MemWr = 1'b0; Size = 2'b10; Addr = 32'h500;
        tick();
        start = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int c = 1; c <= TO_CYC; c++) begin
            check("to_req", mem_req, 1'b1);
            tick();
        end
        check("to_done", done, 1'b1);
        check("to_flag", timeout, 1'b1);
        check("to_req_drop", mem_req, 1'b0);
        check("to_rdata", RData, exp_rdata);
        tick();
        check("to_pulse", done, 1'b0);
`else
        for (int c = 1; c <= 3 * TO_CYC; c++) begin
            check("hang_req", mem_req, 1'b1);
            check("hang_to", timeout, 1'b0);
            tick();
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`endif
        // A fresh access clears any error flag.
        run_access(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h89ABCDEF, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
